// File: rtl/resnet_input_stream_source.sv
// Pull-mode C x Y x X tile stream source feeding one resnet global-wrapper read port.
// Optional RESNET_SRC_LFSR_EN replaces the ramp with a 16-bit Fibonacci LFSR.
module resnet_input_stream_source #(
  parameter int WIDTH  = 16,
  parameter int TILE_X = 8,
  parameter int TILE_Y = 8,
  parameter int TILE_C = 4,
  parameter int START  = 0,
  parameter int STEP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     read_en,
  output logic [WIDTH-1:0]         read_data [0:0],
  output logic [((TILE_X > 1) ? $clog2(TILE_X) : 1)-1:0] tile_x,
  output logic [((TILE_Y > 1) ? $clog2(TILE_Y) : 1)-1:0] tile_y,
  output logic [((TILE_C > 1) ? $clog2(TILE_C) : 1)-1:0] tile_c,
  output logic                     last,
  output logic                     done,
  output logic [31:0]              word_count,
  output logic                     err_overrun
);

  localparam int XW = (TILE_X > 1) ? $clog2(TILE_X) : 1;
  localparam int YW = (TILE_Y > 1) ? $clog2(TILE_Y) : 1;
  localparam int CW = (TILE_C > 1) ? $clog2(TILE_C) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(TILE_X - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(TILE_Y - 1);
  localparam logic [CW-1:0] C_MAX = CW'(TILE_C - 1);

`ifdef RESNET_SRC_LFSR_EN
  if (WIDTH != 16) begin : g_width_check
    $error("resnet_input_stream_source: LFSR pattern requires WIDTH == 16");
  end

  // A zero seed would lock the LFSR, so START=0 falls back to 1.
  localparam logic [WIDTH-1:0] SEED = (START == 0) ? WIDTH'(1) : WIDTH'(START);

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
    return {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
  endfunction
`else
  localparam logic [WIDTH-1:0] SEED = WIDTH'(START);

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
    return d + WIDTH'(STEP);
  endfunction
`endif

  typedef enum logic {STREAM, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data;

  assign read_data[0] = data;
  assign last = (state == STREAM) && (tile_x == X_MAX) && (tile_y == Y_MAX) && (tile_c == C_MAX);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= STREAM;
      data       <= SEED;
      tile_x     <= '0;
      tile_y     <= '0;
      tile_c     <= '0;
      done       <= 1'b0;
      word_count <= '0;
      if (rst) err_overrun <= 1'b0;
    end else begin
      case (state)
        STREAM: begin
          if (read_en) begin
            if (word_count != '1) word_count <= word_count + 32'd1;
            // The final word stays presented: data and coordinates freeze in DONE.
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              data <= advance(data);
              if (tile_x == X_MAX) begin
                tile_x <= '0;
                if (tile_y == Y_MAX) begin
                  tile_y <= '0;
                  tile_c <= tile_c + 1'b1;
                end else begin
                  tile_y <= tile_y + 1'b1;
                end
              end else begin
                tile_x <= tile_x + 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (read_en) err_overrun <= 1'b1;
        end
        default: state <= STREAM;
      endcase
    end
  end

endmodule

// File: tb/tb_resnet_input_stream_source.sv
// Self-checking bench for resnet_input_stream_source: a 2x2x2 ramp source and a 3x2x2
// wrapping-ramp source are checked against a consumed-word-count reference model.
module tb_resnet_input_stream_source;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic read_en = 1'b0;

  always #5 clk = ~clk;

  // Instance a: 2x2x2, START=0, STEP=1
  logic [15:0] rd_a [0:0];
  logic        xa, ya, ca;
  logic        last_a, done_a, err_a;
  logic [31:0] wc_a;

  // Instance b: 3x2x2, START=FFFE, STEP=3
  logic [15:0] rd_b [0:0];
  logic [1:0]  xb;
  logic        yb, cb;
  logic        last_b, done_b, err_b;
  logic [31:0] wc_b;

  resnet_input_stream_source #(
    .WIDTH(16), .TILE_X(2), .TILE_Y(2), .TILE_C(2), .START(0), .STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .read_en(read_en),
    .read_data(rd_a), .tile_x(xa), .tile_y(ya), .tile_c(ca),
    .last(last_a), .done(done_a), .word_count(wc_a), .err_overrun(err_a)
  );

  resnet_input_stream_source #(
    .WIDTH(16), .TILE_X(3), .TILE_Y(2), .TILE_C(2), .START(16'hFFFE), .STEP(3)
  ) dut_w (
    .clk(clk), .rst(rst), .flush(flush), .read_en(read_en),
    .read_data(rd_b), .tile_x(xb), .tile_y(yb), .tile_c(cb),
    .last(last_b), .done(done_b), .word_count(wc_b), .err_overrun(err_b)
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference model state: words consumed since reset/flush, and sticky overrun.
  int unsigned n_a = 0, n_b = 0;
  logic        e_a = 1'b0, e_b = 1'b0;

  function automatic logic [15:0] word_at(int unsigned idx, logic [15:0] start, logic [15:0] step);
    logic [15:0] d;
    logic [31:0] prod;
`ifdef RESNET_SRC_LFSR_EN
    d = (start == 16'h0) ? 16'h0001 : start;
    for (int unsigned i = 0; i < idx; i++) d = {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
    if (step == 16'h0) d = d;
`else
    prod = idx * 32'(step);
    d = start + prod[15:0];
`endif
    return d;
  endfunction

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(int unsigned total, inout int unsigned n, inout logic e);
    if (rst) begin
      n = 0;
      e = 1'b0;
    end else if (flush) begin
      n = 0;
    end else if (read_en) begin
      if (n < total) n++;
      else e = 1'b1;
    end
  endtask

  task automatic check_all(string tag);
    int unsigned ia, ib;
    ia = (n_a == 8) ? 7 : n_a;
    ib = (n_b == 12) ? 11 : n_b;
    cmp({tag, ".a.data"}, 32'(rd_a[0]), 32'(word_at(ia, 16'h0000, 16'h0001)));
    cmp({tag, ".a.x"},    32'(xa), ia % 2);
    cmp({tag, ".a.y"},    32'(ya), (ia / 2) % 2);
    cmp({tag, ".a.c"},    32'(ca), ia / 4);
    cmp({tag, ".a.last"}, 32'(last_a), 32'(n_a == 7));
    cmp({tag, ".a.done"}, 32'(done_a), 32'(n_a == 8));
    cmp({tag, ".a.wc"},   wc_a, n_a);
    cmp({tag, ".a.err"},  32'(err_a), 32'(e_a));
    cmp({tag, ".b.data"}, 32'(rd_b[0]), 32'(word_at(ib, 16'hFFFE, 16'h0003)));
    cmp({tag, ".b.x"},    32'(xb), ib % 3);
    cmp({tag, ".b.y"},    32'(yb), (ib / 3) % 2);
    cmp({tag, ".b.c"},    32'(cb), ib / 6);
    cmp({tag, ".b.last"}, 32'(last_b), 32'(n_b == 11));
    cmp({tag, ".b.done"}, 32'(done_b), 32'(n_b == 12));
    cmp({tag, ".b.wc"},   wc_b, n_b);
    cmp({tag, ".b.err"},  32'(err_b), 32'(e_b));
  endtask

  task automatic step(logic r, logic f, logic en, string tag);
    rst = r;
    flush = f;
    read_en = en;
    @(posedge clk);
    #1;
    model_update(8, n_a, e_a);
    model_update(12, n_b, e_b);
    check_all(tag);
  endtask

  initial begin
    #1;
    // Reset state
    step(1'b1, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b0, "idle");

    // Back-to-back reads across the whole 2x2x2 tile, then done
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, "burst");
    step(1'b0, 1'b0, 1'b0, "done_hold");

    // Overrun, flush keeps it, reset clears it
    step(1'b0, 1'b0, 1'b1, "overrun");
    step(1'b0, 1'b0, 1'b0, "overrun_hold");
    step(1'b0, 1'b1, 1'b0, "flush_keeps_err");
    step(1'b0, 1'b0, 1'b0, "post_flush");
    step(1'b1, 1'b0, 1'b0, "rst_clears_err");

    // Toggled read enable
    step(1'b0, 1'b0, 1'b1, "toggle1");
    step(1'b0, 1'b0, 1'b0, "toggle0");
    step(1'b0, 1'b0, 1'b1, "toggle1b");
    step(1'b0, 1'b0, 1'b0, "toggle0b");

    // Flush together with read_en mid-tile drops the read
    step(1'b0, 1'b0, 1'b1, "pre_flush");
    step(1'b0, 1'b1, 1'b1, "flush_with_read");
    step(1'b0, 1'b0, 1'b0, "after_flush");

    // rst and flush together
    step(1'b1, 1'b1, 1'b1, "rst_and_flush");

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)), "random");
    end

    // Drain both tiles fully and overrun them
    step(1'b0, 1'b1, 1'b0, "drain_flush");
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b1, "drain");
    step(1'b0, 1'b0, 1'b0, "drain_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/resnet_input_stream_source.md
# resnet_input_stream_source

Synthesizable pull-mode stream source that sits directly upstream of the `resnet` accelerator and drives one of its global-wrapper read ports (`hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read` or the kernel equivalent). It presents one word per cycle, advances only when the accelerator asserts its read enable, and walks a C×Y×X tile in that order. It is instantiated once per accelerator input port, for on-FPGA bring-up without a host DMA.

## Interface
- `WIDTH`, 16: data word width.
- `TILE_X`, 8: innermost extent, ≥1.
- `TILE_Y`, 8: middle extent, ≥1.
- `TILE_C`, 4: outermost extent, ≥1.
- `START`, 0: first word value; LFSR seed when the LFSR pattern is compiled in.
- `STEP`, 1: increment between consecutive words in ramp mode.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous restart of the pattern; same priority as `rst` except that `err_overrun` is kept.
- `read_en` in 1: accelerator consumes `read_data[0]` this cycle.
- `read_data` out `[WIDTH-1:0] [0:0]`: current word, registered; unpacked single-element array matching the accelerator port.
- `tile_x`, `tile_y`, `tile_c` out `$clog2(extent)` (min 1): coordinates of the word currently presented.
- `last` out 1: the current word is the final word of the tile.
- `done` out 1: the whole tile has been consumed.
- `word_count` out 32: number of words consumed since reset or flush.
- `err_overrun` out 1: sticky; `read_en` was seen while `done` was high.

## Operation
- Two states, STREAM and DONE. Reset and `flush` go to STREAM.
- Reset values: `read_data[0]`=START[WIDTH-1:0], coordinates 0, `done`=0, `word_count`=0, `err_overrun`=0. `last`=1 only if TILE_X=TILE_Y=TILE_C=1.
- STREAM, `read_en`=1:
  - `read_data` ← `read_data`+STEP, modulo 2^WIDTH.
  - `word_count`++.
  - x increments. x wraps to 0 at TILE_X−1 and carries into y; y wraps at TILE_Y−1 and carries into c.
  - If `last`=1 when consumed, go to DONE with `done`=1. Coordinates and data hold their final values.
- STREAM, `read_en`=0: all state holds.
- DONE:
  - `read_en`=1 sets `err_overrun`, which stays set until `rst`.
  - Data, coordinates, `word_count` and `done` hold.
- `last` = (x=TILE_X−1)&(y=TILE_Y−1)&(c=TILE_C−1) & STREAM. It is combinational from registered state.
- `rst` has priority over `flush`; both have priority over `read_en` in the same cycle.
- `word_count` saturates at 2^32−1.

## Timing
- Zero-latency pull: a word is valid while presented. The accelerator samples `read_data[0]` in the cycle it asserts `read_en`, and the next word appears one cycle after that edge.
- Back-to-back `read_en` yields one new word per cycle with no bubbles.
- `done` rises in the cycle after the last word is consumed.
- `err_overrun` rises in the cycle after the offending `read_en`.
- A `flush` or `rst` in the middle of a tile restarts from START/(0,0,0) on the next cycle. Any `read_en` in the flush cycle is dropped and not counted.

## Configuration
- `RESNET_SRC_LFSR_EN`
  - Defined: the ramp is replaced by a 16-bit Fibonacci LFSR. Advance rule: next = {d[14:0], d[15]^d[13]^d[12]^d[10]}. The seed is START, or 16'h0001 if START=0. STEP is ignored, and WIDTH must be 16; elaboration fails otherwise.
  - Undefined: ramp mode as described in Operation.
  - All control, counting and error behaviour is identical in both modes.

## Test plan
- Reset, then TILE 2×2×2, START=0, STEP=1, `read_en` held high:
  - data sequence 0..7;
  - `last` is high with data=7 and coordinates (1,1,1);
  - `done`=1 the next cycle, `word_count`=8.
- `read_en` toggling 1,0,1,0: data advances only on the enabled edges, and the coordinates hold during idle cycles.
- After `done`, pulse `read_en` once:
  - `err_overrun`=1 the next cycle;
  - `flush` then clears `done` and restarts data at START with `err_overrun` still 1;
  - `rst` clears `err_overrun`.
- START=16'hFFFE, STEP=3, WIDTH=16: sequence FFFE, 0001, 0004 (modulo wrap).
- `flush` and `read_en` high together in the middle of a tile: the next cycle shows data=START, `word_count`=0, coordinates 0.
- With `RESNET_SRC_LFSR_EN` and START=0: sequence 0001, 0002, 0004, …; the 15th advance yields 8000 and the next yields 0001.
